gray_ptr_sync: RTL and testbench
================================

# gray_ptr_sync

Parametrised multi-flop synchroniser for Gray-coded FIFO pointers crossing into the local clock domain. It is the successor to the fixed 4-bit two-flop synchroniser. It adds configurable width and stage count, registered Gray-to-binary decode, a per-cycle pointer advance count, and an optional multi-bit-change checker. It sits on the read side (write pointer in) or write side (read pointer in) of the async FIFO and feeds the full/empty/level logic.

## Interface
- WIDTH, 4: pointer width in bits, including the FIFO wrap bit; legal range ≥2.
- STAGES, 2: number of synchronising flops; legal range ≥2; values <2 are an elaboration error.
- clk  in  1  local-domain clock; every register is on its rising edge.
- rst  in  1  asynchronous, active-low reset; asserts immediately, releases on `clk`.
- gray_in  in  WIDTH  Gray pointer from the remote domain; asynchronous to `clk`.
- sync_gray  out  WIDTH  synchronised Gray pointer (last stage of the chain).
- bin_ptr  out  WIDTH  registered binary decode of `sync_gray`.
- delta  out  WIDTH  binary advance since the previous cycle, modulo 2^WIDTH.
- changed  out  1  high for one cycle when `delta != 0`.
- err  out  1  sticky multi-bit-change flag; present only with the checker macro.

## Operation
- Sync chain:
  - stage[0] <= gray_in
  - stage[i] <= stage[i-1]
  - sync_gray = stage[STAGES-1]
- Every edge updates the decode registers:
  - prev_gray <= sync_gray
  - bin_ptr <= gray2bin(sync_gray)
  - delta <= gray2bin(sync_gray) − bin_ptr, truncated to WIDTH (modular subtraction)
  - changed <= (gray2bin(sync_gray) != bin_ptr)
- Wrap-around: moving from binary 2^WIDTH−1 to 0 gives delta = 1 with no special case.
- Multiple steps: if the remote pointer moves several steps between local edges, delta carries the full count. The FIFO level logic accumulates delta and never assumes a step of 1.
- Checker: err <= err | (popcount(sync_gray ^ prev_gray) > 1).
  - Once set, err stays set until rst.
  - The checker does not alter bin_ptr or delta.
- Reset values: every stage, prev_gray, sync_gray, bin_ptr and delta are 0; changed and err are 0.
- Reset mid-operation: all registers clear asynchronously. After release, the chain refills from gray_in. The first decode after refill reports delta equal to the full pointer value (measured from 0), and changed = 1 if that value is non-zero.

## Timing
- Latency, gray_in stable → sync_gray: STAGES rising edges.
- Latency, gray_in stable → bin_ptr, delta, changed: STAGES+1 edges.
- err has the same alignment as changed.
- changed is a single-cycle pulse per observed change. A pointer that changes on consecutive local cycles gives consecutive pulses.
- Throughput: one pointer value per cycle; no handshake and no back-pressure.
- Input contract: gray_in changes at most one bit per remote clock. The checker exists to catch violations of this contract.
- All outputs are registered; there are no combinational paths from gray_in.

## Configuration
- SYNC_GRAY_CHECK_EN defined:
  - prev_gray popcount checker and `err` port are compiled in.
- SYNC_GRAY_CHECK_EN undefined:
  - `err` port is absent and the checker logic is removed.
  - prev_gray remains only if some other logic uses it; otherwise it is removed.
  - All other outputs are cycle-identical to the defined build.

## Structure
- Shared package `fifo_sync_pkg` holds:
  - `gray2bin` and `bin2gray` functions, parametrised by width
  - `popcount_gt1` helper function
  - constant `SYNC_STAGES_MIN = 2`
- Sub-module `sync_chain`:
  - WIDTH × STAGES flop array with asynchronous active-low reset
  - carries the synthesis attributes that keep the stages as dedicated synchroniser flops
  - reusable for single-bit control crossings

## Test plan
- Reset, gray_in = 4'b0110 held during rst low; release rst → first edge after release shows all outputs 0; sync_gray = 0110 after 2 edges; bin_ptr = 4, delta = 4, changed = 1 at edge 3; edge 4: delta = 0, changed = 0.
- Count sequence, binary 0..15 as Gray, one value per clk, STAGES = 2 → bin_ptr follows with 3-cycle lag; delta = 1 and changed = 1 every cycle; err = 0.
- Wrap: gray_in 4'b1000 (binary 15) → 4'b0000 → delta = 1 and changed = 1 on the wrap cycle.
- Multi-step: Gray of binary 3 → Gray of binary 5 (held ≥2 cycles each) → delta = 2 and changed = 1 for one cycle; err = 1 (two bits differ) with SYNC_GRAY_CHECK_EN defined; err stays 1 until rst.
- STAGES = 3, WIDTH = 6: step gray_in 0 → 1 → sync_gray updates after exactly 3 edges and bin_ptr after 4.
- Assert rst low mid-count at binary 9 → all outputs 0 immediately, without waiting for an edge; after release, the first decode shows delta = current pointer value.

Source files
------------

// File: rtl/fifo_sync_pkg.sv
// Shared helpers for async-FIFO pointer crossings: Gray/binary conversion,
// multi-bit-change detection and the minimum synchroniser depth.
package fifo_sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int PTR_MAX_WIDTH   = 32;

  typedef logic [PTR_MAX_WIDTH-1:0] ptr_t;

  // Callers zero-extend narrower pointers into ptr_t; zero upper bits decode
  // to zero, so the result is correct for any width up to PTR_MAX_WIDTH.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int i = 1; i < PTR_MAX_WIDTH; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic popcount_gt1(input ptr_t x);
    return (x & (x - ptr_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/gray_ptr_sync_if.sv
// Pointer-crossing bundle between the remote Gray pointer and the local
// decode outputs; err exists only when SYNC_GRAY_CHECK_EN is defined.
interface gray_ptr_sync_if #(parameter int WIDTH = 4);

  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] sync_gray;
  logic [WIDTH-1:0] bin_ptr;
  logic [WIDTH-1:0] delta;
  logic             changed;
`ifdef SYNC_GRAY_CHECK_EN
  logic             err;

  modport master (output gray_in, input sync_gray, bin_ptr, delta, changed, err);
  modport slave  (input gray_in, output sync_gray, bin_ptr, delta, changed, err);
`else
  modport master (output gray_in, input sync_gray, bin_ptr, delta, changed);
  modport slave  (input gray_in, output sync_gray, bin_ptr, delta, changed);
`endif

endinterface

// File: rtl/sync_chain.sv
// WIDTH x STAGES synchroniser flop array with asynchronous active-low reset;
// usable for pointer buses and single-bit control crossings alike.
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Keep these as dedicated, tightly placed synchroniser flops (no SRL packing).
  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO", DONT_TOUCH = "TRUE" *)
  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Gray pointer synchroniser with registered binary decode and per-cycle advance.
// Define SYNC_GRAY_CHECK_EN to compile in the sticky multi-bit-change checker (err).
module gray_ptr_sync
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  gray_ptr_sync_if.slave bus
);

  if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("gray_ptr_sync: STAGES must be at least %0d", SYNC_STAGES_MIN);
  end
  if (WIDTH < 2 || WIDTH > PTR_MAX_WIDTH) begin : g_bad_width
    $error("gray_ptr_sync: WIDTH must be in 2..%0d", PTR_MAX_WIDTH);
  end

  logic [WIDTH-1:0] sync_gray;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] bin_ptr_q;
  logic [WIDTH-1:0] delta_q;
  logic             changed_q;

  sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_sync_chain (
    .clk (clk),
    .rst (rst),
    .d   (bus.gray_in),
    .q   (sync_gray)
  );

  assign bin_next = WIDTH'(gray2bin(ptr_t'(sync_gray)));

  // Modular difference carries multi-step moves and the wrap without special cases.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_ptr_q <= '0;
      delta_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      bin_ptr_q <= bin_next;
      delta_q   <= bin_next - bin_ptr_q;
      changed_q <= (bin_next != bin_ptr_q);
    end
  end

  assign bus.sync_gray = sync_gray;
  assign bus.bin_ptr   = bin_ptr_q;
  assign bus.delta     = delta_q;
  assign bus.changed   = changed_q;

`ifdef SYNC_GRAY_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic             err_q;

  // Observation only: a flagged violation never alters bin_ptr or delta.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_gray <= '0;
      err_q     <= 1'b0;
    end else begin
      prev_gray <= sync_gray;
      err_q     <= err_q | popcount_gt1(ptr_t'(sync_gray ^ prev_gray));
    end
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Randomised and directed checks of gray_ptr_sync against a pointer-level
// reference model; err checks are active when SYNC_GRAY_CHECK_EN is defined.
module tb_gray_ptr_sync;

  localparam int W  = 4;
  localparam int S  = 2;
  localparam int W6 = 6;
  localparam int S6 = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gray_ptr_sync_if #(.WIDTH(W))  bus4 ();
  gray_ptr_sync_if #(.WIDTH(W6)) bus6 ();

  gray_ptr_sync #(.WIDTH(W), .STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  gray_ptr_sync #(.WIDTH(W6), .STAGES(S6)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  // Model: pointer values seen by the local domain, newest first.
  int in_q[$];
  int m_sync, m_sync_prev, m_bin, m_delta;
  bit m_changed, m_err;

  function automatic int to_gray(int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int to_bin(int g);
    for (int b = 0; b < (1 << W); b++) begin
      if (to_gray(b) == g) return b;
    end
    return 0;
  endfunction

  function void model_reset();
    in_q.delete();
    for (int i = 0; i < S; i++) in_q.push_back(0);
    m_sync = 0; m_sync_prev = 0; m_bin = 0; m_delta = 0;
    m_changed = 1'b0; m_err = 1'b0;
  endfunction

  function void model_step(int g);
    int nb;
    nb          = to_bin(m_sync);
    m_delta     = (nb - m_bin + (1 << W)) % (1 << W);
    m_changed   = (nb != m_bin);
    m_bin       = nb;
    m_err       = m_err | ($countones(m_sync ^ m_sync_prev) > 1);
    m_sync_prev = m_sync;
    in_q.push_front(g);
    m_sync = in_q[S-1];
    void'(in_q.pop_back());
  endfunction

  function automatic logic [3*W:0] exp_vec();
    return {W'(m_sync), W'(m_bin), W'(m_delta), m_changed};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(int'(bus4.gray_in));
    #1;
  endtask

  task automatic apply_reset(input int g);
    rst = 1'b0;
    bus4.gray_in = W'(g);
    bus6.gray_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [3*W:0] obs;
    rst = 1'b0;
    bus4.gray_in = 4'b0110;
    bus6.gray_in = '0;
    model_reset();
    #1;
    obs = {bus4.sync_gray, bus4.bin_ptr, bus4.delta, bus4.changed};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %h expected 0", obs);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      obs = {bus4.sync_gray, bus4.bin_ptr, bus4.delta, bus4.changed};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL reset_edge%0d: got %h expected %h", e, obs, exp_vec());
      end
      if (e == 3) begin
        checks++;
        if (bus4.bin_ptr !== 4'd4 || bus4.delta !== 4'd4 || bus4.changed !== 1'b1) begin
          errors++;
          $display("[TB] FAIL reset_first_decode: got bin=%0d delta=%0d chg=%b expected 4 4 1",
                   bus4.bin_ptr, bus4.delta, bus4.changed);
        end
      end
      if (e == 4) begin
        checks++;
        if (bus4.delta !== 4'd0 || bus4.changed !== 1'b0) begin
          errors++;
          $display("[TB] FAIL reset_settle: got delta=%0d chg=%b expected 0 0",
                   bus4.delta, bus4.changed);
        end
      end
    end
  endtask

  task automatic test_count_wrap();
    logic [3*W:0] obs;
    apply_reset(0);
    for (int v = 0; v < 21; v++) begin
      bus4.gray_in = W'(to_gray(v % 16));
      tick();
      obs = {bus4.sync_gray, bus4.bin_ptr, bus4.delta, bus4.changed};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL count_v%0d: got %h expected %h", v, obs, exp_vec());
      end
      // Steady count: every decode from the fourth edge on is a single step.
      if (v >= 3) begin
        checks++;
        if (bus4.delta !== 4'd1 || bus4.changed !== 1'b1) begin
          errors++;
          $display("[TB] FAIL count_step_v%0d: got delta=%0d chg=%b expected 1 1",
                   v, bus4.delta, bus4.changed);
        end
      end
`ifdef SYNC_GRAY_CHECK_EN
      checks++;
      if (bus4.err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL count_err_v%0d: got %b expected 0", v, bus4.err);
      end
`endif
    end
  endtask

  task automatic test_multi_step();
    logic [3*W:0] obs;
    int pulses;
    pulses = 0;
    apply_reset(to_gray(3));
    repeat (4) tick();
    bus4.gray_in = W'(to_gray(5));
    for (int c = 0; c < 10; c++) begin
      tick();
      obs = {bus4.sync_gray, bus4.bin_ptr, bus4.delta, bus4.changed};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL multi_c%0d: got %h expected %h", c, obs, exp_vec());
      end
      if (bus4.changed === 1'b1) begin
        pulses++;
        checks++;
        if (bus4.delta !== 4'd2) begin
          errors++;
          $display("[TB] FAIL multi_delta: got %0d expected 2", bus4.delta);
        end
      end
`ifdef SYNC_GRAY_CHECK_EN
      checks++;
      if (bus4.err !== m_err) begin
        errors++;
        $display("[TB] FAIL multi_err_c%0d: got %b expected %b", c, bus4.err, m_err);
      end
`endif
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("[TB] FAIL multi_pulses: got %0d expected 1", pulses);
    end
`ifdef SYNC_GRAY_CHECK_EN
    checks++;
    if (bus4.err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL multi_err_sticky: got %b expected 1", bus4.err);
    end
`endif
  endtask

  task automatic test_random();
    logic [3*W:0] obs;
    int cur, r;
    apply_reset(0);
    cur = 0;
    for (int c = 0; c < 300; c++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       cur = (cur + 1) % 16;
      else if (r == 6) cur = $urandom_range(0, 15);
      bus4.gray_in = W'(to_gray(cur));
      tick();
      obs = {bus4.sync_gray, bus4.bin_ptr, bus4.delta, bus4.changed};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random_c%0d: got %h expected %h", c, obs, exp_vec());
      end
`ifdef SYNC_GRAY_CHECK_EN
      checks++;
      if (bus4.err !== m_err) begin
        errors++;
        $display("[TB] FAIL random_err_c%0d: got %b expected %b", c, bus4.err, m_err);
      end
`endif
    end
  endtask

  task automatic test_stages3();
    apply_reset(0);
    repeat (5) tick();
    bus6.gray_in = 6'd1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (bus6.sync_gray !== ((e >= 3) ? 6'd1 : 6'd0)) begin
        errors++;
        $display("[TB] FAIL s3_sync_e%0d: got %0d expected %0d", e, bus6.sync_gray, (e >= 3) ? 1 : 0);
      end
      checks++;
      if (bus6.bin_ptr !== ((e >= 4) ? 6'd1 : 6'd0) || bus6.changed !== (e == 4)) begin
        errors++;
        $display("[TB] FAIL s3_bin_e%0d: got bin=%0d chg=%b expected %0d %b",
                 e, bus6.bin_ptr, bus6.changed, (e >= 4) ? 1 : 0, e == 4);
      end
    end
  endtask

  task automatic test_reset_midcount();
    logic [3*W:0] obs;
    apply_reset(0);
    for (int v = 0; v <= 9; v++) begin
      bus4.gray_in = W'(to_gray(v));
      tick();
    end
    repeat (4) tick();
    checks++;
    if (bus4.bin_ptr !== 4'd9) begin
      errors++;
      $display("[TB] FAIL mid_pre: got bin=%0d expected 9", bus4.bin_ptr);
    end
    @(posedge clk);
    model_step(int'(bus4.gray_in));
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    obs = {bus4.sync_gray, bus4.bin_ptr, bus4.delta, bus4.changed};
    checks++;
    if (obs !== '0 || bus6.sync_gray !== '0 || bus6.bin_ptr !== '0) begin
      errors++;
      $display("[TB] FAIL mid_async_clear: got %h / %0d %0d expected all 0",
               obs, bus6.sync_gray, bus6.bin_ptr);
    end
`ifdef SYNC_GRAY_CHECK_EN
    checks++;
    if (bus4.err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_err_clear: got %b expected 0", bus4.err);
    end
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      obs = {bus4.sync_gray, bus4.bin_ptr, bus4.delta, bus4.changed};
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL mid_edge%0d: got %h expected %h", e, obs, exp_vec());
      end
      if (e == 3) begin
        checks++;
        if (bus4.delta !== 4'd9 || bus4.changed !== 1'b1) begin
          errors++;
          $display("[TB] FAIL mid_first_decode: got delta=%0d chg=%b expected 9 1",
                   bus4.delta, bus4.changed);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_multi_step();
    test_random();
    test_stages3();
    test_reset_midcount();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
